// File: rtl/mul32_seq_pkg.sv
// Shared definitions for the sequential shift-add multiplier: FSM encoding and iteration count.
package mul32_seq_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StRun  = 2'b01,
    StDone = 2'b10
  } state_e;

  localparam int unsigned NumIter = 32;
  localparam int unsigned CntW    = 5;

endpackage

// File: rtl/cla32_ov.sv
// 32-bit carry-lookahead adder (4-bit lookahead groups) with carry-out and carry into the MSB.
module cla32_ov (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        ci,
  output logic [31:0] s,
  output logic        co,
  output logic        co_prev
);

  logic [31:0] g;
  logic [31:0] pr;
  logic [31:0] cvec;
  logic        carry;
  logic        grp_g;
  logic        grp_p;

  assign g  = a & b;
  assign pr = a ^ b;

  // Group carry is kept in a local variable so the carry vector never feeds itself.
  always_comb begin
    cvec  = '0;
    carry = ci;
    grp_g = 1'b0;
    grp_p = 1'b0;
    for (int k = 0; k < 8; k++) begin
      cvec[4*k]   = carry;
      cvec[4*k+1] = g[4*k] | (pr[4*k] & carry);
      cvec[4*k+2] = g[4*k+1] | (pr[4*k+1] & g[4*k]) | (pr[4*k+1] & pr[4*k] & carry);
      cvec[4*k+3] = g[4*k+2] | (pr[4*k+2] & g[4*k+1]) | (pr[4*k+2] & pr[4*k+1] & g[4*k])
                  | (pr[4*k+2] & pr[4*k+1] & pr[4*k] & carry);
      grp_g = g[4*k+3] | (pr[4*k+3] & g[4*k+2]) | (pr[4*k+3] & pr[4*k+2] & g[4*k+1])
            | (pr[4*k+3] & pr[4*k+2] & pr[4*k+1] & g[4*k]);
      grp_p = &pr[4*k +: 4];
      carry = grp_g | (grp_p & carry);
    end
    co = carry;
  end

  assign s       = pr ^ cvec;
  assign co_prev = cvec[31];

endmodule

// File: rtl/mul32_seq.sv
// Unsigned 32x32 sequential multiplier: one shift-add step per cycle, 32 steps, registered product.
module mul32_seq
  import mul32_seq_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [63:0] p,
  output logic        hi_nz
);

  state_e            state_q, state_d;
  logic [63:0]       prod_q, prod_d;
  logic [31:0]       mcand_q, mcand_d;
  logic [CntW-1:0]   cnt_q, cnt_d;

  logic [31:0] add_b;
  logic [31:0] sum;
  logic        co;
  logic        unused_co_prev;

  assign add_b = prod_q[0] ? mcand_q : 32'd0;

  cla32_ov u_add (
    .a      (prod_q[63:32]),
    .b      (add_b),
    .ci     (1'b0),
    .s      (sum),
    .co     (co),
    .co_prev(unused_co_prev)
  );

  // The adder carry lives in P[63] after each shift, so clearing P clears it too.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      prod_q  <= '0;
      mcand_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      prod_q  <= prod_d;
      mcand_q <= mcand_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    prod_d  = prod_q;
    mcand_d = mcand_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          mcand_d = a;
          prod_d  = {32'd0, b};
          cnt_d   = '0;
          state_d = StRun;
        end else if (state_q == StDone) begin
          state_d = StIdle;
        end
      end
      StRun: begin
        prod_d = {co, sum, prod_q[31:1]};
        cnt_d  = cnt_q + CntW'(1);
        if (cnt_q == CntW'(NumIter - 1)) begin
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy  = (state_q == StRun);
    done  = (state_q == StDone);
    p     = prod_q;
    hi_nz = |prod_q[63:32];
  end

endmodule

// File: tb/tb_mul32_seq.sv
// Directed bench for mul32_seq: latency, products, ignored restarts, mid-run reset, back-to-back.
module tb_mul32_seq;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy;
  logic        done;
  logic [63:0] p;
  logic        hi_nz;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mul32_seq dut (
    .clk    (clk),
    .reset_n(reset_n),
    .start  (start),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .p      (p),
    .hi_nz  (hi_nz)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called in cycle k+1; leaves the bench in cycle k+33.
  task automatic wait_run(input string tag);
    for (int i = 1; i <= 32; i++) begin
      check({tag, " busy"}, 64'(busy), 64'd1);
      check({tag, " done early"}, 64'(done), 64'd0);
      step();
    end
  endtask

  task automatic check_done(input string tag, input logic [63:0] exp_p, input logic exp_hi);
    check({tag, " done"}, 64'(done), 64'd1);
    check({tag, " busy at done"}, 64'(busy), 64'd0);
    check({tag, " p"}, p, exp_p);
    check({tag, " hi_nz"}, 64'(hi_nz), 64'(exp_hi));
  endtask

  task automatic run_op(input string tag, input logic [31:0] va, input logic [31:0] vb,
                        input logic [63:0] exp_p, input logic exp_hi);
    a = va;
    b = vb;
    start = 1'b1;
    step();
    start = 1'b0;
    wait_run(tag);
    check_done(tag, exp_p, exp_hi);
    step();
    check({tag, " done one cycle"}, 64'(done), 64'd0);
    check({tag, " p held"}, p, exp_p);
  endtask

  logic [31:0] bb_a [4];
  logic [31:0] bb_b [4];
  logic [63:0] bb_p [4];

  initial begin
    bb_a[0] = 32'd100;        bb_b[0] = 32'd200;        bb_p[0] = 64'd20000;
    bb_a[1] = 32'h0001_0000;  bb_b[1] = 32'h0001_0000;  bb_p[1] = 64'h0000_0001_0000_0000;
    bb_a[2] = 32'hDEAD_BEEF;  bb_b[2] = 32'd1;          bb_p[2] = 64'h0000_0000_DEAD_BEEF;
    bb_a[3] = 32'h8000_0000;  bb_b[3] = 32'd3;          bb_p[3] = 64'h0000_0001_8000_0000;

    #2;
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset p", p, 64'd0);
    check("reset hi_nz", 64'(hi_nz), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;

    run_op("3x5", 32'd3, 32'd5, 64'h0000_0000_0000_000F, 1'b0);
    run_op("ffxff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b1);
    run_op("0x1234", 32'd0, 32'h1234_5678, 64'd0, 1'b0);
    run_op("msb carry", 32'h8000_0000, 32'd2, 64'h0000_0001_0000_0000, 1'b1);

    // Second start during RUN must be ignored.
    a = 32'd7;
    b = 32'd9;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 1; i <= 32; i++) begin
      check("ignore busy", 64'(busy), 64'd1);
      check("ignore done early", 64'(done), 64'd0);
      if (i == 10) begin
        a = 32'd2;
        b = 32'd2;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      step();
    end
    check_done("ignore", 64'd63, 1'b0);
    step();

    // Reset during RUN aborts without a done pulse.
    a = 32'd11;
    b = 32'd13;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 1; i < 15; i++) step();
    reset_n = 1'b0;
    #1;
    check("abort busy", 64'(busy), 64'd0);
    check("abort done", 64'(done), 64'd0);
    check("abort p", p, 64'd0);
    step();
    step();
    check("abort no done", 64'(done), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    run_op("6x7", 32'd6, 32'd7, 64'd42, 1'b0);

    // start held high: a done every 33 cycles, no idle gap.
    a = bb_a[0];
    b = bb_b[0];
    start = 1'b1;
    step();
    for (int n = 0; n < 4; n++) begin
      if (n < 3) begin
        a = bb_a[n+1];
        b = bb_b[n+1];
      end else begin
        start = 1'b0;
        a = 32'hA5A5_A5A5;
        b = 32'h5A5A_5A5A;
      end
      wait_run($sformatf("b2b%0d", n));
      check_done($sformatf("b2b%0d", n), bb_p[n], bb_p[n][63:32] != 32'd0);
      step();
      if (n < 3) begin
        check($sformatf("b2b%0d no gap", n), 64'(busy), 64'd1);
      end else begin
        check("b2b idle", 64'(busy), 64'd0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mul32_seq.md
MUL32_SEQ -- requirements
Module: mul32_seq

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed at 32-bit operands and a 64-bit product.
REQ-002 The port clk SHALL be an input, 1 bit wide: the single clock; all state updates on its rising edge.
REQ-003 The port reset_n SHALL be an input, 1 bit wide: reset, asynchronous, active-low.
REQ-004 The port start SHALL be an input, 1 bit wide: request to begin a multiply; it is a single-cycle pulse or a level.
REQ-005 The port a SHALL be an input, 32 bits wide: the multiplicand, unsigned.
REQ-006 The port b SHALL be an input, 32 bits wide: the multiplier, unsigned.
REQ-007 The port busy SHALL be an output, 1 bit wide: high while an operation is iterating.
REQ-008 The port done SHALL be an output, 1 bit wide: a one-cycle pulse signalling that the product is valid.
REQ-009 The port p SHALL be an output, 64 bits wide: the product, registered.
REQ-010 The port hi_nz SHALL be an output, 1 bit wide: high when p[63:32] is nonzero (the result does not fit in 32 bits).

Function
REQ-011 The block SHALL implement a 3-state FSM: IDLE, RUN, DONE.
REQ-012 In IDLE or DONE, start=1 at a rising edge SHALL latch a into the multiplicand register, load b into P[31:0], clear P[63:32] and the carry bit, clear the 5-bit iteration counter, and enter RUN.
REQ-013 In RUN, each cycle SHALL do the following: if P[0]=1, {carry, upper} = P[63:32] + multiplicand (ci=0); otherwise {carry, upper} = {0, P[63:32]}. Then P <= {carry, upper, P[31:1]}, and the counter increments.
REQ-014 The adder carry-out (co) SHALL be the sole source of the bit shifted into P[63]; no carry is lost.
REQ-015 RUN SHALL last exactly 32 cycles; when the counter wraps from 31 to 0, the FSM SHALL enter DONE.
REQ-016 DONE SHALL last one cycle and then return to IDLE, unless start=1, which takes the REQ-012 path directly (back-to-back operations).
REQ-017 The busy output SHALL equal (state==RUN).
REQ-018 The done output SHALL equal (state==DONE), high for exactly one cycle per operation.
REQ-019 Latency SHALL be as follows: with start accepted at edge k, busy is high for cycles k+1..k+32 and done is high in cycle k+33.
REQ-020 The p output SHALL be driven from the P register and is architecturally valid from done until the next start is accepted; in IDLE, p SHALL hold the last product.
REQ-021 The block SHALL ignore start while in RUN; operands a and b SHALL be don't-care after acceptance.
REQ-022 The hi_nz output SHALL be combinational from the P register (|P[63:32]).
REQ-023 Operands of 0 SHALL still take the full 32 iterations; there is no early termination.

Reset
REQ-024 On reset_n=0, the block SHALL asynchronously set state=IDLE, P=0, multiplicand=0, counter=0, and carry=0, giving busy=0, done=0, p=0, and hi_nz=0.
REQ-025 Reset asserted mid-RUN SHALL abort the operation with no done pulse, and the block SHALL accept start on the first edge after reset_n rises.

Structure
REQ-026 The state encoding (IDLE=2'b00, RUN=2'b01, DONE=2'b10) and the iteration count constant (32) SHALL be defined in a shared package/include file used by the ALU blocks.
REQ-027 The 32-bit addition SHALL use one instance of the team's existing cla32_ov adder with ci tied to 0, co consumed as the shift-in carry, and co_prev left unconnected; there SHALL be no other sub-modules.
REQ-028 All registers SHALL be in one clocked process; next-state and adder-operand muxing SHALL be combinational.

Verification
REQ-029 The bench SHALL drive a=3, b=5, start pulsed at edge k and require busy high for 32 cycles, then done in cycle k+33, with p=64'h0000_0000_0000_000F and hi_nz=0.
REQ-030 The bench SHALL drive a=b=32'hFFFF_FFFF and require p=64'hFFFF_FFFE_0000_0001 and hi_nz=1 at done.
REQ-031 The bench SHALL drive a=0, b=32'h1234_5678 and require done still at k+33, with p=0.
REQ-032 The bench SHALL start with a=7, b=9, then pulse start with a=2, b=2 at cycle k+10, and require that the second start is ignored, with p=63 at done.
REQ-033 The bench SHALL assert reset_n=0 at cycle k+15 of a run and require busy, done, and p all 0 immediately; after release, start with a=6, b=7 and require p=42.
REQ-034 The bench SHALL hold start=1 continuously with changing operands and require a done every 33 cycles with the correct product each time and no idle cycle between operations.
